uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/rx_sync.sv | 23 ++
 rtl/uart_rx_param.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver family: FSM state encodings,
// parity mode constants and the parity-error helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rxState_t;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parityErrOf(input logic [MAX_DATA_BITS-1:0] word,
                                         input logic                     parBit,
                                         input int                       mode);
        if (mode == PARITY_NONE) begin
            return 1'b0;
        end
        return ((^word) ^ parBit) != (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an idle-high serial line. Resets to 1 so that
// reset never looks like a start bit. Shared with the transmitter loopback.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: start, DATA_BITS data bits (LSB first),
// optional parity and 1-2 stop bits, oversampled at CLKS_PER_BIT.
// Build option UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 majority
// around the sample point instead of a single sample.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level
// START     | checking the start bit at its centre (false-start filter)
// DATA      | shifting in data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bits; strobe issued after the last one
// WAIT_HIGH | after a framing error, waiting for the line to return high
import uart_pkg::*;

module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [DATA_BITS-1:0] leds
);

    localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID_PT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_PT = CNT_W'(CLKS_PER_BIT - 1);

    rxState_t             state;
    rxState_t             nextState;
    logic                 rxSync;
    logic                 rxLine;
    logic                 rxSample;
    logic [CNT_W-1:0]     bitCnt;
    logic [CNT_W-1:0]     samplePoint;
    logic                 atPoint;
    logic [3:0]           bitIdx;
    logic                 lastData;
    logic                 lastStop;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parBit;
    logic                 frameAcc;

    rx_sync uSync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx),
        .dout (rxSync)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rxDly1;
    logic rxDly2;

    // The FSM watches the line one cycle late, so the live synchronised value
    // is the point+1 sample and the vote is centred on the FSM's sample point.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxDly1 <= 1'b1;
            rxDly2 <= 1'b1;
        end else begin
            rxDly1 <= rxSync;
            rxDly2 <= rxDly1;
        end
    end

    assign rxLine   = rxDly1;
    assign rxSample = (rxSync & rxDly1) | (rxSync & rxDly2) | (rxDly1 & rxDly2);
`else
    assign rxLine   = rxSync;
    assign rxSample = rxSync;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!rxLine) nextState = START;
            end
            START: begin
                if (atPoint) nextState = rxSample ? IDLE : DATA;
            end
            DATA: begin
                if (atPoint && lastData) nextState = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                if (atPoint) nextState = STOP;
            end
            STOP: begin
                if (atPoint && lastStop) nextState = (frameAcc || !rxSample) ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: begin
                if (rxLine) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Sample-point and bit-position decode, plus the debug LED view.
    always_comb begin
        samplePoint = (state == START) ? MID_PT : END_PT;
        atPoint     = (bitCnt == samplePoint);
        lastData    = (bitIdx == 4'(DATA_BITS - 1));
        lastStop    = (bitIdx == 4'(STOP_BITS - 1));
        leds        = (parity_err || frame_err) ? '1 : data_out;
    end

    // Bit timing, shift register and the output word/flags with their strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt     <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            parBit     <= 1'b0;
            frameAcc   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE || state == WAIT_HIGH) begin
                bitCnt   <= '0;
                bitIdx   <= '0;
                frameAcc <= 1'b0;
            end else begin
                bitCnt <= atPoint ? '0 : bitCnt + 1'b1;
            end
            if (atPoint) begin
                case (state)
                    DATA: begin
                        shiftReg <= {rxSample, shiftReg[DATA_BITS-1:1]};
                        bitIdx   <= lastData ? 4'd0 : bitIdx + 4'd1;
                    end
                    PARITY: begin
                        parBit <= rxSample;
                    end
                    STOP: begin
                        bitIdx <= bitIdx + 4'd1;
                        if (!rxSample) frameAcc <= 1'b1;
                        if (lastStop) begin
                            data_out   <= shiftReg;
                            data_valid <= 1'b1;
                            parity_err <= parityErrOf(MAX_DATA_BITS'(shiftReg), parBit, PARITY_MODE);
                            frame_err  <= frameAcc | ~rxSample;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: DUT A uses the default configuration,
// DUT B uses 2 stop bits and no parity for the back-to-back case.
module tb_uart_rx_param;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxA = 1'b1;
    logic       rxB = 1'b1;
    logic [7:0] dataA, ledsA, dataB, ledsB;
    logic       validA, perrA, ferrA, validB, perrB, ferrB;

    int errors = 0;
    int checks = 0;
    int cntA = 0, cntB = 0, dblA = 0, dblB = 0;
    logic prevValidA = 1'b0, prevValidB = 1'b0;
    logic [7:0] dataQB[$];
    logic       errQB[$];

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) uA (
        .clk(clk), .rst(rst), .rx(rxA), .data_out(dataA), .data_valid(validA),
        .parity_err(perrA), .frame_err(ferrA), .leds(ledsA)
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) uB (
        .clk(clk), .rst(rst), .rx(rxB), .data_out(dataB), .data_valid(validB),
        .parity_err(perrB), .frame_err(ferrB), .leds(ledsB)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (validA) begin
            cntA++;
            if (prevValidA) dblA++;
        end
        if (validB) begin
            cntB++;
            if (prevValidB) dblB++;
            dataQB.push_back(dataB);
            errQB.push_back(perrB | ferrB);
        end
        prevValidA = validA;
        prevValidB = validB;
    end

    task automatic bitPeriod(input bit sel, input logic v);
        if (sel) rxB = v;
        else     rxA = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic sendFrame(input bit sel, input logic [8:0] data, input int nBits,
                             input bit hasPar, input logic parBit, input int nStop,
                             input logic stopVal);
        bitPeriod(sel, 1'b0);
        for (int i = 0; i < nBits; i++) bitPeriod(sel, data[i]);
        if (hasPar) bitPeriod(sel, parBit);
        for (int i = 0; i < nStop; i++) bitPeriod(sel, stopVal);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", dataA); end
        checks++; if (validA !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", validA); end
        checks++; if (perrA !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b want=0", perrA); end
        checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b want=0", ferrA); end
        checks++; if (ledsA !== 8'h00) begin errors++; $display("FAIL reset_leds got=%h want=00", ledsA); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame;
        int c0;
        c0 = cntA;
        sendFrame(1'b0, 9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1);
        bitPeriod(1'b0, 1'b1);
        checks++; if (cntA !== c0 + 1) begin errors++; $display("FAIL good_strobes got=%0d want=%0d", cntA - c0, 1); end
        checks++; if (dataA !== 8'hA5) begin errors++; $display("FAIL good_data got=%h want=a5", dataA); end
        checks++; if (perrA !== 1'b0) begin errors++; $display("FAIL good_perr got=%b want=0", perrA); end
        checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL good_ferr got=%b want=0", ferrA); end
        checks++; if (ledsA !== 8'hA5) begin errors++; $display("FAIL good_leds got=%h want=a5", ledsA); end
    endtask

    task automatic test_parity_err;
        int c0;
        c0 = cntA;
        sendFrame(1'b0, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1);
        bitPeriod(1'b0, 1'b1);
        checks++; if (cntA !== c0 + 1) begin errors++; $display("FAIL par_strobes got=%0d want=%0d", cntA - c0, 1); end
        checks++; if (dataA !== 8'h07) begin errors++; $display("FAIL par_data got=%h want=07", dataA); end
        checks++; if (perrA !== 1'b1) begin errors++; $display("FAIL par_perr got=%b want=1", perrA); end
        checks++; if (ferrA !== 1'b0) begin errors++; $display("FAIL par_ferr got=%b want=0", ferrA); end
        checks++; if (ledsA !== 8'hFF) begin errors++; $display("FAIL par_leds got=%h want=ff", ledsA); end
    endtask

    task automatic test_frame_err;
        int c0;
        c0 = cntA;
        sendFrame(1'b0, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b0);
        checks++; if (cntA !== c0 + 1) begin errors++; $display("FAIL ferr_strobes got=%0d want=%0d", cntA - c0, 1); end
        checks++; if (dataA !== 8'h3C) begin errors++; $display("FAIL ferr_data got=%h want=3c", dataA); end
        checks++; if (ferrA !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b want=1", ferrA); end
        checks++; if (ledsA !== 8'hFF) begin errors++; $display("FAIL ferr_leds got=%h want=ff", ledsA); end
        for (int i = 0; i < 40; i++) bitPeriod(1'b0, 1'b0);
        checks++; if (cntA !== c0 + 1) begin errors++; $display("FAIL ferr_low_strobes got=%0d want=%0d", cntA - c0, 1); end
        bitPeriod(1'b0, 1'b1);
        bitPeriod(1'b0, 1'b1);
        sendFrame(1'b0, 9'h055, 8, 1'b1, 1'b0, 1, 1'b1);
        bitPeriod(1'b0, 1'b1);
        checks++; if (cntA !== c0 + 2) begin errors++; $display("FAIL recov_strobes got=%0d want=%0d", cntA - c0, 2); end
        checks++; if (dataA !== 8'h55) begin errors++; $display("FAIL recov_data got=%h want=55", dataA); end
        checks++; if ((perrA | ferrA) !== 1'b0) begin errors++; $display("FAIL recov_flags got=%b%b want=00", perrA, ferrA); end
        checks++; if (ledsA !== 8'h55) begin errors++; $display("FAIL recov_leds got=%h want=55", ledsA); end
    endtask

    task automatic test_false_start;
        int c0;
        c0 = cntA;
        rxA = 1'b0;
        repeat (5) @(negedge clk);
        rxA = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (uA.state !== IDLE) begin errors++; $display("FAIL glitch_state got=%0d want=%0d", uA.state, IDLE); end
        repeat (40) @(negedge clk);
        checks++; if (cntA !== c0) begin errors++; $display("FAIL glitch_strobes got=%0d want=0", cntA - c0); end
    endtask

    task automatic test_reset_mid;
        int c0;
        c0 = cntA;
        bitPeriod(1'b0, 1'b0);
        bitPeriod(1'b0, 1'b1);
        bitPeriod(1'b0, 1'b0);
        bitPeriod(1'b0, 1'b1);
        bitPeriod(1'b0, 1'b0);
        rxA = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        rxA = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (dataA !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h want=00", dataA); end
        checks++; if (ledsA !== 8'h00) begin errors++; $display("FAIL rstmid_leds got=%h want=00", ledsA); end
        checks++; if ((validA | perrA | ferrA) !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b%b%b want=000", validA, perrA, ferrA); end
        repeat (48) @(negedge clk);
        checks++; if (cntA !== c0) begin errors++; $display("FAIL rstmid_strobes got=%0d want=0", cntA - c0); end
        sendFrame(1'b0, 9'h081, 8, 1'b1, 1'b0, 1, 1'b1);
        bitPeriod(1'b0, 1'b1);
        checks++; if (cntA !== c0 + 1) begin errors++; $display("FAIL after_rst_strobes got=%0d want=1", cntA - c0); end
        checks++; if (dataA !== 8'h81) begin errors++; $display("FAIL after_rst_data got=%h want=81", dataA); end
        checks++; if (ledsA !== 8'h81) begin errors++; $display("FAIL after_rst_leds got=%h want=81", ledsA); end
    endtask

    task automatic test_back_to_back;
        sendFrame(1'b1, 9'h000, 8, 1'b0, 1'b0, 2, 1'b1);
        sendFrame(1'b1, 9'h0FF, 8, 1'b0, 1'b0, 2, 1'b1);
        bitPeriod(1'b1, 1'b1);
        bitPeriod(1'b1, 1'b1);
        checks++; if (cntB !== 2) begin errors++; $display("FAIL b2b_strobes got=%0d want=2", cntB); end
        checks++;
        if (dataQB.size() < 2) begin
            errors++; $display("FAIL b2b_words got=%0d want=2", dataQB.size());
        end else if (dataQB[0] !== 8'h00 || dataQB[1] !== 8'hFF) begin
            errors++; $display("FAIL b2b_data got=%h,%h want=00,ff", dataQB[0], dataQB[1]);
        end
        checks++;
        if (errQB.size() < 2) begin
            errors++; $display("FAIL b2b_errs got=%0d entries want=2", errQB.size());
        end else if (errQB[0] !== 1'b0 || errQB[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_errs got=%b,%b want=0,0", errQB[0], errQB[1]);
        end
        checks++; if (ledsB !== 8'hFF) begin errors++; $display("FAIL b2b_leds got=%h want=ff", ledsB); end
    endtask

    task automatic test_single_strobe;
        checks++; if (dblA !== 0) begin errors++; $display("FAIL double_valid_a got=%0d want=0", dblA); end
        checks++; if (dblB !== 0) begin errors++; $display("FAIL double_valid_b got=%0d want=0", dblB); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_false_start();
        test_reset_mid();
        test_back_to_back();
        test_single_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
